// File: rtl/dm_responder.sv
// Data-memory responder for the CPU load/store port: one request at a time,
// programmable wait latency, byte/half/word lane handling with sign/zero extension.
module dm_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_dmtype,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_N  = 4'(WAIT_CYCLES);
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_cnt_next;

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_dmtype;

  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_dmtype;
  logic        cur_err;
  logic [IDX_W-1:0] cur_idx;
  logic [31:0] cur_word;

  logic        ready_next;
  logic        valid_next;
  logic [31:0] rdata_next;
  logic        err_next;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic access_err(input logic [31:0] addr, input logic [2:0] dmtype);
    logic align_err;
    logic range_err;
    case (dmtype)
      DM_W:         align_err = (addr[1:0] != 2'b00);
      DM_H, DM_HU:  align_err = addr[0];
      DM_B, DM_BU:  align_err = 1'b0;
      default:      align_err = 1'b1;
    endcase
    range_err = ({2'b00, addr[31:2]} >= DEPTH_L);
    return align_err | range_err;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  dmtype);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (dmtype)
      DM_W:    r = word;
      DM_H:    r = {{16{h[15]}}, h};
      DM_HU:   r = {16'h0000, h};
      DM_B:    r = {{24{b[7]}}, b};
      DM_BU:   r = {24'h000000, b};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  dmtype);
    logic [31:0] r;
    r = old;
    case (dmtype)
      DM_W: r = wdata;
      DM_H, DM_HU: begin
        if (lane[1]) begin
          r[31:16] = wdata[15:0];
        end else begin
          r[15:0] = wdata[15:0];
        end
      end
      DM_B, DM_BU: begin
        case (lane)
          2'b00:   r[7:0]   = wdata[7:0];
          2'b01:   r[15:8]  = wdata[7:0];
          2'b10:   r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      default: r = old;
    endcase
    return r;
  endfunction

  // In IDLE the live request is used so a zero-wait response can be formed on accept.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_we     = req_we;
      cur_addr   = req_addr;
      cur_wdata  = req_wdata;
      cur_dmtype = req_dmtype;
    end else begin
      cur_we     = lat_we;
      cur_addr   = lat_addr;
      cur_wdata  = lat_wdata;
      cur_dmtype = lat_dmtype;
    end
  end

  assign cur_err  = access_err(cur_addr, cur_dmtype);
  assign cur_idx  = cur_addr[IDX_W+1:2];
  assign cur_word = mem[cur_idx];

  // Next-state and wait-counter logic.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          if (WAIT_N != 4'd0) begin
            state_next    = ST_WAIT;
            wait_cnt_next = 4'd1;
          end else begin
            state_next    = ST_RESP;
            wait_cnt_next = 4'd0;
          end
        end else begin
          state_next    = ST_IDLE;
          wait_cnt_next = 4'd0;
        end
      end
      ST_WAIT: begin
        if (wait_cnt >= WAIT_N) begin
          state_next    = ST_RESP;
          wait_cnt_next = 4'd0;
        end else begin
          state_next    = ST_WAIT;
          wait_cnt_next = wait_cnt + 4'd1;
        end
      end
      ST_RESP: begin
        state_next    = ST_IDLE;
        wait_cnt_next = 4'd0;
      end
      default: begin
        state_next    = ST_IDLE;
        wait_cnt_next = 4'd0;
      end
    endcase
  end

  // Output values for the coming cycle, registered so every port is flop-driven.
  always_comb begin
    ready_next = (state_next == ST_IDLE);
    valid_next = (state_next == ST_RESP);
    err_next   = 1'b0;
    rdata_next = 32'h0000_0000;
    if (state_next == ST_RESP) begin
      err_next = cur_err;
      if (!cur_err && !cur_we) begin
        rdata_next = load_extract(cur_word, cur_addr[1:0], cur_dmtype);
      end else begin
        rdata_next = 32'h0000_0000;
      end
    end else begin
      err_next   = 1'b0;
      rdata_next = 32'h0000_0000;
    end
  end

  // State, counter, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= 4'd0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'h0000_0000;
      lat_wdata  <= 32'h0000_0000;
      lat_dmtype <= 3'b000;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_cnt_next;
      req_ready  <= ready_next;
      resp_valid <= valid_next;
      resp_rdata <= rdata_next;
      resp_err   <= err_next;
      if (state == ST_IDLE && req_valid && req_ready) begin
        lat_we     <= req_we;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        lat_dmtype <= req_dmtype;
      end else begin
        lat_we     <= lat_we;
        lat_addr   <= lat_addr;
        lat_wdata  <= lat_wdata;
        lat_dmtype <= lat_dmtype;
      end
    end
  end

  // Store commit on the edge ending RESP; reset aborts it and never clears the array.
  always_ff @(posedge clk) begin
    if (!reset && state == ST_RESP && cur_we && !cur_err) begin
      mem[cur_idx] <= store_merge(cur_word, cur_wdata, cur_addr[1:0], cur_dmtype);
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed lane/error/abort cases, a zero-wait throughput
// instance, and randomized traffic compared each cycle against a transaction-level model.
module tb_dm_responder;

  localparam int DEPTH = 128;
  localparam int W     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_ready, resp_valid, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [2:0]  req_dmtype;

  logic        z_valid, z_we, z_ready, z_resp_valid, z_err;
  logic [31:0] z_addr, z_wdata, z_rdata;
  logic [2:0]  z_dm;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_dmtype(req_dmtype),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err));

  dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(z_valid), .req_ready(z_ready),
    .req_we(z_we), .req_addr(z_addr), .req_wdata(z_wdata), .req_dmtype(z_dm),
    .resp_valid(z_resp_valid), .resp_rdata(z_rdata), .resp_err(z_err));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic bit ref_err(input logic [31:0] a, input logic [2:0] dm);
    int unsigned au;
    au = a;
    if (au / 4 >= DEPTH) return 1'b1;
    if (dm > 3'd4) return 1'b1;
    if (dm == 3'd0) return (au % 4) != 0;
    if (dm == 3'd1 || dm == 3'd2) return (au % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] dm);
    int unsigned v;
    int unsigned off;
    off = a % 4;
    if (dm == 3'd0) return w;
    if (dm == 3'd1 || dm == 3'd2) begin
      v = (w >> (16 * (off / 2))) % 65536;
      if (dm == 3'd1 && v >= 32768) v = v - 65536;
      return v;
    end
    v = (w >> (8 * off)) % 256;
    if (dm == 3'd3 && v >= 128) v = v - 256;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [31:0] a, input logic [2:0] dm);
    logic [31:0] mask;
    int unsigned sh;
    if (dm == 3'd0) begin
      mask = 32'hFFFF_FFFF;
      sh   = 0;
    end else if (dm == 3'd1 || dm == 3'd2) begin
      sh   = 16 * ((a % 4) / 2);
      mask = 32'h0000_FFFF << sh;
    end else begin
      sh   = 8 * (a % 4);
      mask = 32'h0000_00FF << sh;
    end
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  // ---------------- transaction-level model ----------------
  logic [31:0] ref_mem [DEPTH];
  bit          busy = 1'b0;
  int          acc  = 0;
  int          cyc  = 0;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_dm;
  logic        exp_ready, exp_valid, exp_err;
  logic [31:0] exp_rdata;
  bit          chk_en = 1'b0;

  // Accept at cycle N, respond at N+W+1, commit at the end of that cycle.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      busy = 1'b0;
      exp_ready = 1'b1; exp_valid = 1'b0; exp_rdata = 32'h0; exp_err = 1'b0;
    end else begin
      if (!busy) begin
        if (req_valid) begin
          busy = 1'b1; acc = cyc - 1;
          m_we = req_we; m_addr = req_addr; m_wdata = req_wdata; m_dm = req_dmtype;
        end
      end else if (cyc - 1 == acc + W + 1) begin
        if (m_we && !ref_err(m_addr, m_dm))
          ref_mem[m_addr[8:2]] = ref_store(ref_mem[m_addr[8:2]], m_wdata, m_addr, m_dm);
        busy = 1'b0;
      end
      exp_ready = !busy;
      exp_valid = busy && (cyc == acc + W + 1);
      exp_err   = exp_valid && ref_err(m_addr, m_dm);
      exp_rdata = (exp_valid && !exp_err && !m_we) ?
                  ref_load(ref_mem[m_addr[8:2]], m_addr, m_dm) : 32'h0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
      check("resp_valid", {31'd0, resp_valid}, {31'd0, exp_valid});
      check("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
      check("resp_rdata", resp_rdata, exp_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] dm, output logic [31:0] rdata, output logic err);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_dmtype = dm;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (resp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(W + 1));
    rdata = resp_rdata;
    err   = resp_err;
    @(negedge clk);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dm;
    logic [31:0] rd;
    bit          err;
  } op_t;

  op_t dir_ops [15];

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        zwe  [4];
    logic [31:0] zad  [4];
    logic [31:0] zwd  [4];
    logic [2:0]  zdm  [4];
    logic [31:0] zexp [4];

    dir_ops = '{
      '{1'b1, 32'h10,  32'hDEADBEEF, 3'b000, 32'h0,        1'b0},
      '{1'b0, 32'h10,  32'h0,        3'b000, 32'hDEADBEEF, 1'b0},
      '{1'b1, 32'h11,  32'h80,       3'b011, 32'h0,        1'b0},
      '{1'b0, 32'h10,  32'h0,        3'b000, 32'hDEAD80EF, 1'b0},
      '{1'b0, 32'h11,  32'h0,        3'b011, 32'hFFFFFF80, 1'b0},
      '{1'b0, 32'h11,  32'h0,        3'b100, 32'h00000080, 1'b0},
      '{1'b1, 32'h12,  32'h8001,     3'b001, 32'h0,        1'b0},
      '{1'b0, 32'h12,  32'h0,        3'b001, 32'hFFFF8001, 1'b0},
      '{1'b0, 32'h12,  32'h0,        3'b010, 32'h00008001, 1'b0},
      '{1'b0, 32'h10,  32'h0,        3'b000, 32'h800180EF, 1'b0},
      '{1'b0, 32'h13,  32'h0,        3'b000, 32'h0,        1'b1},
      '{1'b0, 32'h11,  32'h0,        3'b001, 32'h0,        1'b1},
      '{1'b1, 32'h200, 32'hFFFFFFFF, 3'b000, 32'h0,        1'b1},
      '{1'b1, 32'h10,  32'h0,        3'b111, 32'h0,        1'b1},
      '{1'b0, 32'h10,  32'h0,        3'b000, 32'h800180EF, 1'b0}
    };
    zwe  = '{1'b1, 1'b0, 1'b1, 1'b0};
    zad  = '{32'h40, 32'h40, 32'h41, 32'h40};
    zwd  = '{32'hCAFEF00D, 32'h0, 32'h5A, 32'h0};
    zdm  = '{3'b000, 3'b000, 3'b011, 3'b000};
    zexp = '{32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFE5A0D};

    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_dmtype = 3'b000;
    z_valid = 1'b0; z_we = 1'b0; z_addr = 32'h0; z_wdata = 32'h0; z_dm = 3'b000;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);

    // Directed lane and error cases on the two-wait instance.
    for (int i = 0; i < 15; i++) begin
      xfer(dir_ops[i].we, dir_ops[i].addr, dir_ops[i].wdata, dir_ops[i].dm, rd, er);
      check($sformatf("dir%0d_rdata", i), rd, dir_ops[i].rd);
      check($sformatf("dir%0d_err", i), {31'd0, er}, {31'd0, dir_ops[i].err});
    end

    // Zero-wait instance with req_valid held high: ready and valid alternate.
    z_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("z_ready", {31'd0, z_ready}, {31'd0, (k % 2) == 0});
      check("z_valid", {31'd0, z_resp_valid}, {31'd0, (k % 2) == 1});
      if ((k % 2) == 1) begin
        check($sformatf("z_rdata%0d", k / 2), z_rdata, zexp[k / 2]);
        check("z_err", {31'd0, z_err}, 32'd0);
      end else begin
        z_we = zwe[k / 2]; z_addr = zad[k / 2]; z_wdata = zwd[k / 2]; z_dm = zdm[k / 2];
      end
      @(negedge clk);
    end
    z_valid = 1'b0;

    // Give every word touched by random traffic a defined value.
    for (int i = 0; i < 16; i++) xfer(1'b1, 32'(i * 4), $urandom(), 3'b000, rd, er);

    // Reset during WAIT aborts the store.
    xfer(1'b1, 32'h20, 32'h0BADF00D, 3'b000, rd, er);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_dmtype = 3'b000;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_valid", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    xfer(1'b0, 32'h20, 32'h0, 3'b000, rd, er);
    check("abort_prior_value", rd, 32'h0BADF00D);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      int unsigned word;
      reset      = ($urandom_range(0, 299) == 0);
      req_valid  = ($urandom_range(0, 2) != 0);
      req_we     = 1'(($urandom_range(0, 1)));
      req_dmtype = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                               : 3'($urandom_range(0, 4));
      word       = ($urandom_range(0, 19) == 0) ? DEPTH + $urandom_range(0, 63)
                                                : $urandom_range(0, 15);
      req_addr   = 32'(word * 4 + $urandom_range(0, 3));
      req_wdata  = $urandom();
      @(negedge clk);
    end
    reset = 1'b0;
    req_valid = 1'b0;
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
